// File: rtl/exe2wb_stage.sv
// exe2wb_stage: holds one EXE result, waits on data memory, and drives register write-back plus forwarding
module exe2wb_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        flush,
  input  logic [31:0] instruction_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] csr_in,
  input  logic        Reg_WE_in,
  input  logic [1:0]  DMEM_sel_in,
  input  logic [2:0]  LOAD_sel_in,
  input  logic [1:0]  WB_sel_in,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_commit,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] PC_out,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        mem_err
);
  typedef enum logic [1:0] {EMPTY, FULL, MEM_WAIT} state_t;
  state_t state, nxt;
  logic [4:0]  rd_q;
  logic [31:0] alu_q, csr_q;
  logic        we_q;
  logic [2:0]  lsel_q;
  logic [1:0]  wsel_q;
  logic [7:0]  timer;
  logic        timeout, done, abort, accept, mem_in, unused_instr;
  logic [31:0] shifted, load_v, raw;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign unused_instr = ^{instruction_in[31:12], instruction_in[6:0]};
  assign mem_in    = (DMEM_sel_in != 2'd0) | (WB_sel_in == 2'd0 & Reg_WE_in);
  assign timeout   = state == MEM_WAIT && timer == 8'(MEM_TIMEOUT);
  assign done      = state == MEM_WAIT && (dmem_ready || timeout);
  assign abort     = timeout & ~dmem_ready;
  assign ready_out = state != MEM_WAIT || dmem_ready || timeout;
  assign accept    = valid_in & ready_out & ~flush;
  assign shifted   = dmem_rdata >> {alu_q[1:0], 3'b000};
  assign byte_v    = shifted[7:0];
  assign half_v    = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  // load extraction and write-back source selection; data reads as zero while empty
  always_comb begin
    load_v = LOAD_sel_q_is(3'd0) ? {{24{byte_v[7]}}, byte_v} :
             LOAD_sel_q_is(3'd1) ? {{16{half_v[15]}}, half_v} :
             LOAD_sel_q_is(3'd3) ? {24'd0, byte_v} :
             LOAD_sel_q_is(3'd4) ? {16'd0, half_v} : dmem_rdata;
    raw = wsel_q == 2'd1 ? alu_q : wsel_q == 2'd2 ? PC_out + 32'd4 : wsel_q == 2'd3 ? csr_q : load_v;
  end
  function automatic logic LOAD_sel_q_is(input logic [2:0] v);
    return lsel_q == v;
  endfunction
  assign wb_commit = (state == FULL & ~flush) | done;
  assign wb_we     = wb_commit & we_q & (rd_q != 5'd0) & ~(done & abort);
  assign wb_rd     = rd_q;
  assign wb_data   = state == EMPTY ? 32'd0 : raw;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wb_data;
  assign fwd_valid = we_q & (rd_q != 5'd0) & ((state == FULL & wsel_q != 2'd0) | (state == MEM_WAIT & dmem_ready));
  // next state: a new accept wins, otherwise a retiring op leaves the stage empty
  always_comb begin
    nxt = accept ? (mem_in ? MEM_WAIT : FULL) : (state == FULL || done) ? EMPTY : state;
  end
  // state register, memory-wait timer and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      timer   <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state   <= nxt;
      timer   <= (state == MEM_WAIT && !done) ? timer + 8'd1 : 8'd0;
      mem_err <= mem_err | (done & abort);
    end
  end
  // capture the incoming op on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q   <= 5'd0;
      PC_out <= 32'd0;
      alu_q  <= 32'd0;
      csr_q  <= 32'd0;
      we_q   <= 1'b0;
      lsel_q <= 3'd0;
      wsel_q <= 2'd0;
    end else if (accept) begin
      rd_q   <= instruction_in[11:7];
      PC_out <= PC_in;
      alu_q  <= alu_in;
      csr_q  <= csr_in;
      we_q   <= Reg_WE_in;
      lsel_q <= LOAD_sel_in;
      wsel_q <= WB_sel_in;
    end
  end
endmodule

// File: tb/tb_exe2wb_stage.sv
// tb_exe2wb_stage: randomized scenario bench for exe2wb_stage against a transaction-level model
module tb_exe2wb_stage;
  logic clk = 0, rst = 0, valid_in = 0, flush = 0, Reg_WE_in = 0, dmem_ready = 0;
  logic [31:0] instruction_in = 0, PC_in = 0, alu_in = 0, csr_in = 0, dmem_rdata = 0;
  logic [1:0] DMEM_sel_in = 0, WB_sel_in = 0;
  logic [2:0] LOAD_sel_in = 0;
  logic ready_out, wb_commit, wb_we, fwd_valid, mem_err;
  logic [4:0] wb_rd, fwd_rd;
  logic [31:0] wb_data, PC_out, fwd_data;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [4:0] rd; logic [31:0] pc, alu, csr; logic we;
    logic [1:0] dsel; logic [2:0] lsel; logic [1:0] wsel;
  } op_t;

  exe2wb_stage #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .flush(flush),
    .instruction_in(instruction_in), .PC_in(PC_in), .alu_in(alu_in), .csr_in(csr_in),
    .Reg_WE_in(Reg_WE_in), .DMEM_sel_in(DMEM_sel_in), .LOAD_sel_in(LOAD_sel_in),
    .WB_sel_in(WB_sel_in), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_commit(wb_commit), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .PC_out(PC_out),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_data(input op_t o, input logic [31:0] rdata);
    longint unsigned b, h;
    b = (longint'(rdata) >> ((o.alu % 4) * 8)) % 256;
    h = (longint'(rdata) >> (((o.alu / 2) % 2) * 16)) % 65536;
    if (o.wsel == 1) return o.alu;
    if (o.wsel == 2) return 32'(o.pc + 4);
    if (o.wsel == 3) return o.csr;
    case (o.lsel)
      0: return 32'(b >= 128 ? b + 64'hFFFFFF00 : b);
      1: return 32'(h >= 32768 ? h + 64'hFFFF0000 : h);
      3: return 32'(b);
      4: return 32'(h);
      default: return rdata;
    endcase
  endfunction

  function automatic logic is_mem(input op_t o);
    return o.dsel != 0 || (o.wsel == 0 && o.we);
  endfunction

  function automatic logic exp_we(input op_t o);
    return o.we && o.rd != 0;
  endfunction

  function automatic op_t gen_op(input int kind);
    op_t o;
    o.rd = 5'($urandom); o.pc = $urandom; o.alu = $urandom; o.csr = $urandom;
    o.lsel = 3'($urandom);
    if (kind == 0) begin o.dsel = 0; o.wsel = 2'($urandom_range(1, 3)); o.we = 1'($urandom); end
    else if (kind == 1) begin o.dsel = 0; o.wsel = 0; o.we = 1; end
    else begin o.dsel = 2'($urandom_range(1, 3)); o.wsel = 2'($urandom); o.we = 0; end
    return o;
  endfunction

  task automatic put(input op_t o, input logic v);
    valid_in = v;
    instruction_in = $urandom;
    instruction_in[11:7] = o.rd;
    PC_in = o.pc; alu_in = o.alu; csr_in = o.csr; Reg_WE_in = o.we;
    DMEM_sel_in = o.dsel; LOAD_sel_in = o.lsel; WB_sel_in = o.wsel;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input op_t o, input int lat, input logic [31:0] rdata);
    put(o, 1);
    tick;
    valid_in = 0;
    if (is_mem(o)) begin
      repeat (lat) begin
        #1;
        n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL rnd_wait_ready: got %b want 0", ready_out); end
        n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL rnd_wait_commit: got %b want 0", wb_commit); end
        tick;
      end
      dmem_ready = 1; dmem_rdata = rdata;
    end else dmem_ready = 1'($urandom);
    #1;
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL rnd_commit: got %b want 1", wb_commit); end
    n_cmp++; if (wb_we !== exp_we(o)) begin n_err++; $display("FAIL rnd_we: got %b want %b", wb_we, exp_we(o)); end
    n_cmp++; if (wb_rd !== o.rd) begin n_err++; $display("FAIL rnd_rd: got %0d want %0d", wb_rd, o.rd); end
    n_cmp++; if (wb_data !== ref_data(o, rdata)) begin n_err++; $display("FAIL rnd_data: got %h want %h", wb_data, ref_data(o, rdata)); end
    n_cmp++; if (PC_out !== o.pc) begin n_err++; $display("FAIL rnd_pc: got %h want %h", PC_out, o.pc); end
    n_cmp++; if (fwd_valid !== (exp_we(o) && (is_mem(o) || o.wsel != 0))) begin n_err++; $display("FAIL rnd_fwd_valid: got %b", fwd_valid); end
    tick;
    dmem_ready = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    dmem_rdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL reset_commit: got %b want 0", wb_commit); end
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", wb_we); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", wb_data); end
    n_cmp++; if (PC_out !== 32'd0) begin n_err++; $display("FAIL reset_pc: got %h want 0", PC_out); end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    n_cmp++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL reset_fwd: got %b want 0", fwd_valid); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_out); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_alu;
    op_t o;
    o = gen_op(0);
    o.rd = 5; o.alu = 32'h1234; o.we = 1; o.wsel = 1;
    put(o, 1);
    tick;
    valid_in = 0;
    #1;
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL alu_commit: got %b want 1", wb_commit); end
    n_cmp++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", wb_we); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d want 5", wb_rd); end
    n_cmp++; if (wb_data !== 32'h1234) begin n_err++; $display("FAIL alu_data: got %h want 1234", wb_data); end
    n_cmp++; if (fwd_valid !== 1'b1) begin n_err++; $display("FAIL alu_fwd_valid: got %b want 1", fwd_valid); end
    n_cmp++; if (fwd_data !== 32'h1234) begin n_err++; $display("FAIL alu_fwd_data: got %h want 1234", fwd_data); end
    tick;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL alu_idle_commit: got %b want 0", wb_commit); end
    @(negedge clk);
  endtask

  task automatic test_load(input logic [2:0] lsel, input logic [31:0] want);
    op_t o;
    o = gen_op(1);
    o.rd = 7; o.alu = 32'h0000_0103; o.lsel = lsel;
    put(o, 1);
    tick;
    valid_in = 0;
    repeat (3) begin
      #1;
      n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL load_wait_ready: got %b want 0", ready_out); end
      n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL load_wait_commit: got %b want 0", wb_commit); end
      tick;
    end
    dmem_ready = 1; dmem_rdata = 32'h80FF_FFFF;
    #1;
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL load_commit: got %b want 1", wb_commit); end
    n_cmp++; if (wb_data !== want) begin n_err++; $display("FAIL load_data: got %h want %h", wb_data, want); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b want 1", ready_out); end
    n_cmp++; if (fwd_valid !== 1'b1) begin n_err++; $display("FAIL load_fwd: got %b want 1", fwd_valid); end
    tick;
    dmem_ready = 0;
  endtask

  task automatic test_back_to_back;
    op_t ops[20];
    foreach (ops[i]) ops[i] = gen_op(0);
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) put(ops[i], 1); else valid_in = 0;
      #1;
      n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ready_out); end
      if (i > 0) begin
        n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL b2b_commit[%0d]: got %b want 1", i, wb_commit); end
        n_cmp++; if (wb_rd !== ops[i-1].rd) begin n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, wb_rd, ops[i-1].rd); end
        n_cmp++; if (wb_data !== ref_data(ops[i-1], dmem_rdata)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, wb_data, ref_data(ops[i-1], dmem_rdata)); end
        n_cmp++; if (wb_we !== exp_we(ops[i-1])) begin n_err++; $display("FAIL b2b_we[%0d]: got %b want %b", i, wb_we, exp_we(ops[i-1])); end
      end
      tick;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_op(gen_op($urandom_range(0, 2)), $urandom_range(0, 3), $urandom);
  endtask

  task automatic test_flush;
    op_t o;
    o = gen_op(0); o.rd = 3; o.we = 1;
    put(o, 1);
    tick;
    valid_in = 0; flush = 1;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL flush_full_commit: got %b want 0", wb_commit); end
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL flush_full_we: got %b want 0", wb_we); end
    tick;
    flush = 0;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL flush_after_commit: got %b want 0", wb_commit); end
    @(negedge clk);
    put(o, 1); flush = 1;
    tick;
    flush = 0; valid_in = 0;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL flush_valid_commit: got %b want 0", wb_commit); end
    @(negedge clk);
    o = gen_op(1); o.rd = 9; o.lsel = 2;
    put(o, 1);
    tick;
    put(gen_op(0), 1); flush = 1;
    #1;
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL flush_mw_ready: got %b want 0", ready_out); end
    tick;
    dmem_ready = 1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL flush_mw_commit: got %b want 1", wb_commit); end
    n_cmp++; if (wb_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL flush_mw_data: got %h want cafef00d", wb_data); end
    n_cmp++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL flush_mw_we: got %b want 1", wb_we); end
    tick;
    flush = 0; valid_in = 0; dmem_ready = 0;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL flush_mw_noaccept: got %b want 0", wb_commit); end
    @(negedge clk);
    o = gen_op(0); o.rd = 1; o.we = 1; o.wsel = 2; o.pc = 32'hFFFF_FFFC;
    run_op(o, 0, 0);
  endtask

  task automatic test_timeout;
    op_t o;
    o = gen_op(1); o.rd = 4;
    put(o, 1);
    tick;
    valid_in = 0;
    repeat (4) begin
      #1;
      n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL to_wait_ready: got %b want 0", ready_out); end
      n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL to_wait_commit: got %b want 0", wb_commit); end
      tick;
    end
    #1;
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL to_commit: got %b want 1", wb_commit); end
    n_cmp++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL to_we: got %b want 0", wb_we); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL to_ready: got %b want 1", ready_out); end
    tick;
    #1;
    n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL to_mem_err: got %b want 1", mem_err); end
    @(negedge clk);
    run_op(gen_op(0), 0, 0);
    #1;
    n_cmp++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL to_mem_err_sticky: got %b want 1", mem_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    op_t o;
    o = gen_op(1); o.rd = 12;
    dmem_rdata = 32'h1357_9BDF;
    put(o, 1);
    tick;
    valid_in = 0;
    tick;
    #2 rst = 0;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL rmid_commit: got %b want 0", wb_commit); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_err++; $display("FAIL rmid_rd: got %0d want 0", wb_rd); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL rmid_data: got %h want 0", wb_data); end
    n_cmp++; if (PC_out !== 32'd0) begin n_err++; $display("FAIL rmid_pc: got %h want 0", PC_out); end
    n_cmp++; if (fwd_data !== 32'd0) begin n_err++; $display("FAIL rmid_fwd_data: got %h want 0", fwd_data); end
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rmid_mem_err: got %b want 0", mem_err); end
    @(negedge clk);
    rst = 1; dmem_ready = 1;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL rmid_after_commit: got %b want 0", wb_commit); end
    tick;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL rmid_after2_commit: got %b want 0", wb_commit); end
    dmem_ready = 0;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load(3'd0, 32'hFFFF_FF80);
    test_load(3'd3, 32'h0000_0080);
    test_back_to_back;
    test_random;
    test_flush;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
